// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: fetch/decode/execute sequencing, memory handshake, trap on unknown opcode.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       result_src,
    output logic [1:0]       imm_src,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd15
    } state_t;

    state_t     st_q, st_d;
    logic [2:0] alu_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= FETCH;
        else     st_q <= st_d;
    end

    assign state = st_q;

    // sub only for R-type (op[5]) with funct7b5; I-type addi never subtracts
    always_comb begin
        alu_dec = 3'b000;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec = 3'b000;
        endcase
    end

    always_comb begin
        st_d        = FETCH;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        illegal     = 1'b0;
        case (st_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // state is forced to FETCH while rst is high; keep its loads quiet
                if (mem_ready) begin
                    ir_write = !rst;
                    pc_write = !rst;
                    st_d     = DECODE;
                end else begin
                    st_d = FETCH;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    7'b0000011, 7'b0100011: st_d = MEMADR;
                    7'b0110011:             st_d = EXECR;
                    7'b0010011:             st_d = EXECI;
                    7'b1100011:             st_d = BEQ;
                    7'b1101111:             st_d = JAL;
                    default:                st_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = op[5] ? 2'b01 : 2'b00;
                st_d      = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                st_d    = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                st_d       = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                st_d      = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                st_d        = ALUWB;
            end
            // immediate ALU ops still take rs1 as operand A
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                st_d        = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                st_d      = FETCH;
            end
            BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = zero;
                st_d        = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                reg_write = 1'b1;
                imm_src   = 2'b11;
                st_d      = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                st_d    = TRAP;
            end
            default: st_d = FETCH;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic             retire;
    logic [CNT_W-1:0] ret_q;

    assign retire = (st_d == FETCH) &&
                    (st_q inside {MEMWB, MEMWRITE, ALUWB, BEQ, JAL});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ret_q <= '0;
        else if (retire) ret_q <= ret_q + CNT_W'(1);
    end

    assign retired = ret_q;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues hand-derived per-cycle expectations,
// a negedge monitor pops and compares state, control vector and retired count.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       op = 7'b0;
    logic [2:0]       funct3 = 3'b0;
    logic             funct7b5 = 1'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]       alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]       alu_control;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .result_src(result_src), .imm_src(imm_src), .state(state), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            nm;
        logic [3:0]       st;
        logic [17:0]      v;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] ret_exp = '0;
    logic [17:0]      act_v;

    assign act_v = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_control, result_src, imm_src, illegal};

    function automatic logic [17:0] mk(input logic mq, input logic mw, input logic ad,
                                       input logic iw, input logic pw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] res,
                                       input logic [1:0] imm, input logic il);
        return {mq, mw, ad, iw, pw, rw, a, b, alu, res, imm, il};
    endfunction

    // hand-derived control vectors per state
    logic [17:0] V_F1, V_F0, V_DEC, V_MAL, V_MAS, V_MR, V_MWB, V_MW, V_ALUWB;
    logic [17:0] V_BEQT, V_BEQN, V_JAL, V_TRAP;
    initial begin
        V_F1    = mk(1,0,0,1,1,0, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0);
        V_F0    = mk(1,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0);
        V_DEC   = mk(0,0,0,0,0,0, 2'b01, 2'b01, 3'b000, 2'b00, 2'b10, 0);
        V_MAL   = mk(0,0,0,0,0,0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 0);
        V_MAS   = mk(0,0,0,0,0,0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b01, 0);
        V_MR    = mk(1,0,1,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
        V_MWB   = mk(0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0);
        V_MW    = mk(1,1,1,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
        V_ALUWB = mk(0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
        V_BEQT  = mk(0,0,0,0,1,0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0);
        V_BEQN  = mk(0,0,0,0,0,0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0);
        V_JAL   = mk(0,0,0,0,1,1, 2'b01, 2'b10, 3'b000, 2'b00, 2'b11, 0);
        V_TRAP  = mk(0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1);
    end

    function automatic logic [17:0] v_exr(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b10, 2'b00, alu, 2'b00, 2'b00, 0);
    endfunction

    function automatic logic [17:0] v_exi(input logic [2:0] alu);
        return mk(0,0,0,0,0,0, 2'b10, 2'b01, alu, 2'b00, 2'b00, 0);
    endfunction

    // one clock of stimulus; ret marks a cycle that retires an instruction
    task automatic cyc(input string nm, input logic r, input logic mr, input logic z,
                       input logic [3:0] st, input logic [17:0] v, input bit ret);
        exp_t e;
        rst       = r;
        mem_ready = mr;
        zero      = z;
        if (r) ret_exp = '0;
        e.nm  = nm;
        e.st  = st;
        e.v   = v;
        e.ret = PERF ? ret_exp : '0;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (ret && !r) ret_exp = ret_exp + 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [17:0] vex, input logic [3:0] stex);
        set_instr(o, f3, f7);
        cyc({nm, "_fetch"}, 0, 1, 0, 4'd0, V_F1, 0);
        cyc({nm, "_dec"},   0, 0, 0, 4'd1, V_DEC, 0);
        cyc({nm, "_exec"},  0, 1, 0, stex, vex, 0);
        cyc({nm, "_aluwb"}, 0, 0, 0, 4'd7, V_ALUWB, 1);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL %s state: got %0d want %0d", e.nm, state, e.st);
            end
            n_cmp++;
            if (act_v !== e.v) begin
                n_bad++;
                $display("FAIL %s ctrl: got %b want %b", e.nm, act_v, e.v);
            end
            n_cmp++;
            if (retired !== e.ret) begin
                n_bad++;
                $display("FAIL %s retired: got %0d want %0d", e.nm, retired, e.ret);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // reset holds FETCH outputs, loads suppressed even with mem_ready
        cyc("reset", 1, 1, 0, 4'd0, V_F0, 0);

        // lw, memory always ready
        set_instr(7'b0000011, 3'b010, 0);
        cyc("lw_fetch",  0, 1, 0, 4'd0, V_F1, 0);
        cyc("lw_dec",    0, 1, 0, 4'd1, V_DEC, 0);
        cyc("lw_adr",    0, 1, 0, 4'd2, V_MAL, 0);
        cyc("lw_read",   0, 1, 0, 4'd3, V_MR, 0);
        cyc("lw_wb",     0, 1, 0, 4'd4, V_MWB, 1);

        // fetch stall then sw with three wait cycles
        set_instr(7'b0100011, 3'b010, 0);
        cyc("sw_fwait0", 0, 0, 0, 4'd0, V_F0, 0);
        cyc("sw_fwait1", 0, 0, 0, 4'd0, V_F0, 0);
        cyc("sw_fetch",  0, 1, 0, 4'd0, V_F1, 0);
        cyc("sw_dec",    0, 0, 0, 4'd1, V_DEC, 0);
        cyc("sw_adr",    0, 0, 0, 4'd2, V_MAS, 0);
        for (int i = 0; i < 3; i++) cyc("sw_wait", 0, 0, 0, 4'd5, V_MW, 0);
        cyc("sw_done",   0, 1, 0, 4'd5, V_MW, 1);

        // beq taken then not taken
        set_instr(7'b1100011, 3'b000, 0);
        cyc("beq1_fetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("beq1_dec",   0, 0, 1, 4'd1, V_DEC, 0);
        cyc("beq1_exec",  0, 0, 1, 4'd10, V_BEQT, 1);
        cyc("beq2_fetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("beq2_dec",   0, 0, 0, 4'd1, V_DEC, 0);
        cyc("beq2_exec",  0, 0, 0, 4'd10, V_BEQN, 1);

        // ALU decode: sub only for R-type
        alu_instr("r_sub", 7'b0110011, 3'b000, 1, v_exr(3'b001), 4'd6);
        alu_instr("i_add", 7'b0010011, 3'b000, 1, v_exi(3'b000), 4'd8);
        alu_instr("r_slt", 7'b0110011, 3'b010, 0, v_exr(3'b101), 4'd6);
        alu_instr("r_or",  7'b0110011, 3'b110, 0, v_exr(3'b011), 4'd6);
        alu_instr("r_and", 7'b0110011, 3'b111, 1, v_exr(3'b010), 4'd6);
        alu_instr("i_slt", 7'b0010011, 3'b010, 0, v_exi(3'b101), 4'd8);
        alu_instr("i_xor", 7'b0010011, 3'b100, 0, v_exi(3'b000), 4'd8);

        // jal
        set_instr(7'b1101111, 3'b000, 0);
        cyc("jal_fetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("jal_dec",   0, 0, 0, 4'd1, V_DEC, 0);
        cyc("jal_exec",  0, 0, 0, 4'd9, V_JAL, 1);

        // illegal opcode traps; mem_ready and zero are ignored there
        set_instr(7'b1111111, 3'b000, 1);
        cyc("trap_fetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("trap_dec",   0, 0, 0, 4'd1, V_DEC, 0);
        for (int i = 0; i < 10; i++) cyc("trap_hold", 0, i[0], 1, 4'd15, V_TRAP, 0);
        cyc("trap_rst",   1, 1, 0, 4'd0, V_F0, 0);
        cyc("post_rst",   0, 0, 0, 4'd0, V_F0, 0);

        // 17 ALU ops; a 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++)
            alu_instr("wrap", 7'b0010011, 3'b000, 0, v_exi(3'b000), 4'd8);

        // reset during a pending load abandons it
        set_instr(7'b0000011, 3'b010, 0);
        cyc("mr_fetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("mr_dec",   0, 0, 0, 4'd1, V_DEC, 0);
        cyc("mr_adr",   0, 0, 0, 4'd2, V_MAL, 0);
        cyc("mr_wait",  0, 0, 0, 4'd3, V_MR, 0);
        cyc("mr_rst",   1, 0, 0, 4'd0, V_F0, 0);
        cyc("mr_rel",   0, 0, 0, 4'd0, V_F0, 0);
        cyc("mr_refetch", 0, 1, 0, 4'd0, V_F1, 0);
        cyc("mr_dec2",  0, 0, 0, 4'd1, V_DEC, 0);

        repeat (2) @(posedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 op  input  7  instruction opcode field (instr[6:0]) from instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory completes current request this cycle.
REQ-009 mem_req  output  1  memory access request.
REQ-010 mem_write  output  1  request is a store.
REQ-011 adr_src  output  1  0 = address from PC, 1 = address from ALU result register.
REQ-012 ir_write, pc_write, reg_write  output  1 each  register load enables.
REQ-013 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1 data.
REQ-014 alu_src_b  output  2  00 rs2 data, 01 immediate, 10 constant 4.
REQ-015 alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 result_src  output  2  00 ALU result register, 01 memory data, 10 ALU output.
REQ-017 imm_src  output  2  00 I, 01 S, 10 B, 11 J.
REQ-018 state  output  4  current state encoding; illegal  output  1  high in TRAP; retired  output  CNT_W  instruction count.

Function
REQ-019 States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, TRAP 15; others SHALL go to FETCH next cycle.
REQ-020 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; hold until mem_ready; ir_write=pc_write=1 only in the mem_ready cycle, then DECODE.
REQ-021 DECODE: alu_src_a=01, alu_src_b=01, add, imm_src=10 (branch target); next state by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BEQ, 1101111 JAL, else TRAP.
REQ-022 MEMADR: alu_src_a=10, alu_src_b=01, add, imm_src 00 for load, 01 for store; next MEMREAD (load) or MEMWRITE (store).
REQ-023 MEMREAD: mem_req=1, adr_src=1; wait for mem_ready, then MEMWB. MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-024 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; wait for mem_ready, then FETCH.
REQ-025 EXECR: alu_src_a=10, alu_src_b=00, decoded ALU op; EXECI: alu_src_b=01, imm_src=00, decoded op; both then ALUWB. ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-026 Decoded op from funct3: 000 add (sub when op[5]&funct7b5), 010 slt, 110 or, 111 and, other funct3 add.
REQ-027 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero; then FETCH.
REQ-028 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, reg_write=1, imm_src=11; then FETCH.
REQ-029 TRAP: all enables 0, illegal=1; remains until reset.
REQ-030 Unlisted outputs SHALL be 0 in every state; pc_write, ir_write, reg_write, mem_req never asserted outside the states above.
REQ-031 mem_req SHALL stay asserted, with stable adr_src/mem_write, every cycle until mem_ready; mem_ready outside a requesting state is ignored.

Reset
REQ-032 rst high SHALL asynchronously force state=FETCH, retired=0, illegal=0; outputs take FETCH values except ir_write/pc_write=0 while rst high.
REQ-033 Reset mid-access SHALL abandon the request; no enable asserted in the cycle rst deasserts unless mem_ready is high.

Configuration
REQ-034 Macro MULTICYCLE_CTRL_PERF_EN defined: retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BEQ, JAL, wrapping at 2^CNT_W. Undefined: retired tied to 0, no counter flops.

Verification
REQ-035 lw (op 0000011), mem_ready high each request -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01; 5 cycles.
REQ-036 sw with mem_ready low 3 cycles in MEMWRITE -> mem_req=mem_write=1, adr_src=1 held 4 cycles; FETCH follows; reg_write never 1.
REQ-037 beq with zero=1, then zero=0 -> pc_write=1 in BEQ state first time, 0 second; alu_control=001 both.
REQ-038 R-type funct3=000 funct7b5=1 -> alu_control=001 in EXECR; I-type same fields -> 000 in EXECI.
REQ-039 op=1111111 -> TRAP after DECODE, illegal=1, no enables for 10 cycles; rst pulse -> FETCH, illegal=0.
REQ-040 With MULTICYCLE_CTRL_PERF_EN, CNT_W=4, 17 ALU instructions -> retired=1; rst asserted in MEMREAD -> retired=0, state=0 immediately.
